// File: rtl/bolme_hakem.sv
// bolme_hakem: round-robin arbiter that shares one Q16.16 sequential divider
// among ISTEKCI_SAYISI requesters. Zero divisors are answered directly, and a
// watchdog forces an overflow response if the divider never completes.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   istek                       per-slot request level, held until kabul
//   istek_bolunen, istek_bolen  packed Q16.16 operands, slot i at [32i+31:32i]
//   kabul                       one-hot grant pulse
//   cevap_gecerli               one-hot result-valid pulse to the granted slot
//   cevap_sonuc, cevap_tasma    64-bit result and overflow flag, held
//   mesgul                      sequencer not idle
//   div_baslat, div_bolunen,
//   div_bolen                   start pulse and operands to the divider
//   div_bitti, div_sonuc,
//   div_tasma                   divider completion pulse, result, overflow
module bolme_hakem #(
  parameter int unsigned ISTEKCI_SAYISI = 4,
  parameter int unsigned ZAMAN_ASIMI    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ISTEKCI_SAYISI-1:0]     istek,
  input  logic [ISTEKCI_SAYISI*32-1:0]  istek_bolunen,
  input  logic [ISTEKCI_SAYISI*32-1:0]  istek_bolen,
  output logic [ISTEKCI_SAYISI-1:0]     kabul,
  output logic [ISTEKCI_SAYISI-1:0]     cevap_gecerli,
  output logic [63:0]                   cevap_sonuc,
  output logic                          cevap_tasma,
  output logic                          mesgul,
  output logic                          div_baslat,
  output logic [31:0]                   div_bolunen,
  output logic [31:0]                   div_bolen,
  input  logic                          div_bitti,
  input  logic [63:0]                   div_sonuc,
  input  logic                          div_tasma
);

  localparam int unsigned N  = ISTEKCI_SAYISI;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WW = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;

  typedef enum logic [2:0] {
    BOS    = 3'd0,
    BASLAT = 3'd1,
    SIFIR  = 3'd2,
    BEKLE  = 3'd3,
    CEVAP  = 3'd4
  } durum_t;

  durum_t          durum_q, durum_d;
  logic [IW-1:0]   oncelik_q, oncelik_d;
  logic [IW-1:0]   kazanan_q, kazanan_d;
  logic [WW-1:0]   bekci_q, bekci_d;

  logic [N-1:0]    kabul_d, gecerli_d;
  logic [63:0]     sonuc_d;
  logic            tasma_d, baslat_d, mesgul_d;
  logic [31:0]     bolunen_d, bolen_d;

  logic [31:0]     bolunen_dizi [N];
  logic [31:0]     bolen_dizi   [N];

  logic            bulundu;
  logic [IW-1:0]   aday;
  logic [IW:0]     toplam;
  logic [IW:0]     sonraki;
  logic [IW-1:0]   sonraki_oncelik;

  // Unpack the per-slot operand buses.
  always_comb begin : operand_acma
    for (int unsigned i = 0; i < N; i++) begin
      bolunen_dizi[i] = istek_bolunen[i*32 +: 32];
      bolen_dizi[i]   = istek_bolen[i*32 +: 32];
    end
  end

  // First requesting slot at or after the priority pointer, wrapping mod N.
  always_comb begin : secici
    bulundu = 1'b0;
    aday    = '0;
    toplam  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      toplam = (IW+1)'(oncelik_q) + (IW+1)'(i);
      if (toplam >= (IW+1)'(N)) begin
        toplam = toplam - (IW+1)'(N);
      end
      if (!bulundu && istek[toplam[IW-1:0]]) begin
        bulundu = 1'b1;
        aday    = toplam[IW-1:0];
      end
    end
    sonraki = (IW+1)'(aday) + (IW+1)'(1);
    if (sonraki >= (IW+1)'(N)) begin
      sonraki = '0;
    end
    sonraki_oncelik = sonraki[IW-1:0];
  end

  // Next state and next values of every registered output.
  always_comb begin : sonraki_durum
    durum_d   = durum_q;
    oncelik_d = oncelik_q;
    kazanan_d = kazanan_q;
    bekci_d   = bekci_q;
    bolunen_d = div_bolunen;
    bolen_d   = div_bolen;
    sonuc_d   = cevap_sonuc;
    tasma_d   = cevap_tasma;
    kabul_d   = '0;
    gecerli_d = '0;
    baslat_d  = 1'b0;

    case (durum_q)
      BOS: begin
        if (bulundu) begin
          kazanan_d = aday;
          oncelik_d = sonraki_oncelik;
          bolunen_d = bolunen_dizi[aday];
          bolen_d   = bolen_dizi[aday];
          kabul_d   = N'(1) << aday;
          if (bolen_dizi[aday] == 32'd0) begin
            durum_d = SIFIR;
          end else begin
            durum_d  = BASLAT;
            baslat_d = 1'b1;
          end
        end
      end
      BASLAT: begin
        bekci_d = '0;
        durum_d = BEKLE;
      end
      SIFIR: begin
        sonuc_d   = 64'hFFFF_FFFF_FFFF_FFFF;
        tasma_d   = 1'b1;
        gecerli_d = N'(1) << kazanan_q;
        durum_d   = CEVAP;
      end
      BEKLE: begin
        // Completion wins over a timeout falling in the same cycle.
        if (div_bitti) begin
          sonuc_d   = div_sonuc;
          tasma_d   = div_tasma;
          gecerli_d = N'(1) << kazanan_q;
          durum_d   = CEVAP;
        end else if (bekci_q == WW'(ZAMAN_ASIMI - 1)) begin
          sonuc_d   = '0;
          tasma_d   = 1'b1;
          gecerli_d = N'(1) << kazanan_q;
          durum_d   = CEVAP;
        end else begin
          bekci_d = bekci_q + WW'(1);
        end
      end
      CEVAP: begin
        durum_d = BOS;
      end
      default: begin
        durum_d = BOS;
      end
    endcase

    mesgul_d = (durum_d != BOS);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin : kayitlar
    if (!rst_n) begin
      durum_q       <= BOS;
      oncelik_q     <= '0;
      kazanan_q     <= '0;
      bekci_q       <= '0;
      kabul         <= '0;
      cevap_gecerli <= '0;
      cevap_sonuc   <= '0;
      cevap_tasma   <= 1'b0;
      mesgul        <= 1'b0;
      div_baslat    <= 1'b0;
      div_bolunen   <= '0;
      div_bolen     <= '0;
    end else begin
      durum_q       <= durum_d;
      oncelik_q     <= oncelik_d;
      kazanan_q     <= kazanan_d;
      bekci_q       <= bekci_d;
      kabul         <= kabul_d;
      cevap_gecerli <= gecerli_d;
      cevap_sonuc   <= sonuc_d;
      cevap_tasma   <= tasma_d;
      mesgul        <= mesgul_d;
      div_baslat    <= baslat_d;
      div_bolunen   <= bolunen_d;
      div_bolen     <= bolen_d;
    end
  end

endmodule
